// File: rtl/bcd_led_decoder.sv
// bcd_led_decoder: latches a two-digit BCD switch index and lights its red LED.
// Define DECODER_SWEEP_EN to animate a one-hot sweep up to the index on valid loads.
module bcd_led_decoder #(
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int ERR_BLINKS   = 3,
  parameter int STEP_CYCLES  = 5_000_000
) (
  input  logic        CLOCK_50_I,
  input  logic        RESETN_I,
  input  logic [7:0]  SWITCH_I,
  input  logic [1:0]  PUSH_BUTTON_N_I,
  output logic [17:0] LED_RED_O,
  output logic [8:0]  LED_GREEN_O,
  output logic [3:0]  TENS_O,
  output logic [3:0]  UNITS_O,
  output logic        VALID_O
);

  localparam int BW  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int NPH = 2 * ERR_BLINKS;
  localparam int PW  = (NPH > 1) ? $clog2(NPH) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NPH - 1);

  if (BLINK_CYCLES < 1 || ERR_BLINKS < 1 || STEP_CYCLES < 1) begin : g_bad_param
    $error("bcd_led_decoder: cycle parameters must be positive");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_ERR
`ifdef DECODER_SWEEP_EN
    , S_SWEEP
`endif
  } state_t;

  logic [1:0] btn_s1, btn_s2, btn_s3;
  logic       ld_p, clr_p;

  // Two-flop synchronizer, then a falling-edge detect registered as a pulse
  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      btn_s1 <= '1;
      btn_s2 <= '1;
      btn_s3 <= '1;
      ld_p   <= 1'b0;
      clr_p  <= 1'b0;
    end else begin
      btn_s1 <= PUSH_BUTTON_N_I;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      ld_p   <= btn_s3[0] & ~btn_s2[0];
      clr_p  <= btn_s3[1] & ~btn_s2[1];
    end
  end

  logic [3:0] sw_t, sw_u;
  logic [7:0] sw_sum;
  logic       sw_ok;

  assign sw_t   = SWITCH_I[7:4];
  assign sw_u   = SWITCH_I[3:0];
  assign sw_sum = {1'b0, sw_t, 3'b000} + {3'b000, sw_t, 1'b0} + {4'h0, sw_u};
  assign sw_ok  = (sw_t <= 4'd1) && (sw_u <= 4'd9) && (sw_sum <= 8'd17);

  state_t        state_q, state_d;
  logic [BW-1:0] tmr_q, tmr_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [4:0]    idx_q, idx_d;
  logic          valid_q, valid_d;
  logic [17:0]   red_q, red_d;
  logic [8:0]    green_q, green_d;
  logic          sweep_d;

`ifdef DECODER_SWEEP_EN
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] ST_LAST = SW'(STEP_CYCLES - 1);

  logic [SW-1:0] st_q, st_d;
  logic [4:0]    pos_q, pos_d;

  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      st_q  <= '0;
      pos_q <= '0;
    end else begin
      st_q  <= st_d;
      pos_q <= pos_d;
    end
  end

  assign sweep_d = (state_d == S_SWEEP);
`else
  assign sweep_d = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ph_d    = ph_q;
    tens_d  = tens_q;
    units_d = units_q;
    idx_d   = idx_q;
    valid_d = valid_q;
`ifdef DECODER_SWEEP_EN
    st_d    = st_q;
    pos_d   = pos_q;
`endif
    if (clr_p) begin
      state_d = S_IDLE;
      tens_d  = 4'hF;
      units_d = 4'hF;
      idx_d   = '0;
      valid_d = 1'b0;
    end else if (ld_p) begin
      tmr_d = '0;
      ph_d  = '0;
      if (sw_ok) begin
        tens_d  = sw_t;
        units_d = sw_u;
        idx_d   = sw_sum[4:0];
        valid_d = 1'b1;
`ifdef DECODER_SWEEP_EN
        state_d = S_SWEEP;
        st_d    = '0;
        pos_d   = '0;
`else
        state_d = S_SHOW;
`endif
      end else begin
        state_d = S_ERR;
      end
    end else begin
      unique case (state_q)
        S_ERR: begin
          if (tmr_q == B_LAST) begin
            tmr_d = '0;
            if (ph_q == P_LAST) state_d = valid_q ? S_SHOW : S_IDLE;
            else ph_d = ph_q + 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
`ifdef DECODER_SWEEP_EN
        S_SWEEP: begin
          if (st_q == ST_LAST) begin
            st_d = '0;
            if (pos_q == idx_q) state_d = S_SHOW;
            else pos_d = pos_q + 1'b1;
          end else begin
            st_d = st_q + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register with it
  always_comb begin
    red_d = '0;
    unique case (state_d)
      S_SHOW:  red_d = 18'd1 << idx_d;
      S_ERR:   red_d = ph_d[0] ? '0 : '1;
`ifdef DECODER_SWEEP_EN
      S_SWEEP: red_d = 18'd1 << pos_d;
`endif
      default: red_d = '0;
    endcase
  end

  assign green_d = {idx_d, sweep_d, state_d == S_ERR,
                    state_d == S_SHOW, state_d == S_IDLE};

  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      ph_q    <= '0;
      tens_q  <= 4'hF;
      units_q <= 4'hF;
      idx_q   <= '0;
      valid_q <= 1'b0;
      red_q   <= '0;
      green_q <= 9'h001;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ph_q    <= ph_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      red_q   <= red_d;
      green_q <= green_d;
    end
  end

  assign LED_RED_O   = red_q;
  assign LED_GREEN_O = green_q;
  assign TENS_O      = tens_q;
  assign UNITS_O     = units_q;
  assign VALID_O     = valid_q;

endmodule

// File: tb/tb_bcd_led_decoder.sv
// tb_bcd_led_decoder: directed and random checks of bcd_led_decoder
// against a cycle-level behavioural model of the button/validate/blink rules.
module tb_bcd_led_decoder;

  localparam int B  = 4;
  localparam int EB = 2;
  localparam int S  = 3;

  localparam int M_IDLE  = 0;
  localparam int M_SHOW  = 1;
  localparam int M_ERR   = 2;
  localparam int M_SWEEP = 3;
`ifdef DECODER_SWEEP_EN
  localparam int M_LOAD = M_SWEEP;
`else
  localparam int M_LOAD = M_SHOW;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sw;
  logic [1:0]  btn;
  logic [17:0] red;
  logic [8:0]  green;
  logic [3:0]  tens, units;
  logic        valid;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  bcd_led_decoder #(
    .BLINK_CYCLES(B),
    .ERR_BLINKS(EB),
    .STEP_CYCLES(S)
  ) dut (
    .CLOCK_50_I(clk),
    .RESETN_I(rst_n),
    .SWITCH_I(sw),
    .PUSH_BUTTON_N_I(btn),
    .LED_RED_O(red),
    .LED_GREEN_O(green),
    .TENS_O(tens),
    .UNITS_O(units),
    .VALID_O(valid)
  );

  // hl/hc: button levels seen at the last four edges, [0] newest
  typedef struct packed {
    logic [3:0] hl;
    logic [3:0] hc;
    int         mode;
    int         k;
    logic [3:0] tens;
    logic [3:0] units;
    bit         valid;
  } m_t;

  m_t m;

  function automatic m_t m_rst();
    m_t r;
    r.hl = 4'hF;
    r.hc = 4'hF;
    r.mode = M_IDLE;
    r.k = 0;
    r.tens = 4'hF;
    r.units = 4'hF;
    r.valid = 1'b0;
    return r;
  endfunction

  function automatic int idx_of(m_t x);
    return x.valid ? int'(x.tens) * 10 + int'(x.units) : 0;
  endfunction

  // A press sampled low at edge N (high at N-1) takes effect at edge N+3
  function automatic m_t step(m_t x, logic [1:0] b, logic [7:0] s);
    m_t n;
    bit ld, cl;
    int t, u;
    n = x;
    ld = (x.hl[2] == 1'b0) && (x.hl[3] == 1'b1);
    cl = (x.hc[2] == 1'b0) && (x.hc[3] == 1'b1);
    n.hl = {x.hl[2:0], b[0]};
    n.hc = {x.hc[2:0], b[1]};
    t = int'(s[7:4]);
    u = int'(s[3:0]);
    if (cl) begin
      n.mode = M_IDLE;
      n.tens = 4'hF;
      n.units = 4'hF;
      n.valid = 1'b0;
    end else if (ld) begin
      n.k = 0;
      if (t <= 1 && u <= 9 && t * 10 + u <= 17) begin
        n.tens = s[7:4];
        n.units = s[3:0];
        n.valid = 1'b1;
        n.mode = M_LOAD;
      end else begin
        n.mode = M_ERR;
      end
    end else if (x.mode == M_ERR) begin
      n.k = x.k + 1;
      if (n.k == 2 * EB * B) n.mode = x.valid ? M_SHOW : M_IDLE;
    end else if (x.mode == M_SWEEP) begin
      n.k = x.k + 1;
      if (n.k == (idx_of(x) + 1) * S) n.mode = M_SHOW;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_rst();
    else m <= step(m, btn, sw);
  end

  always @(negedge clk) begin
    int ix;
    logic [17:0] er;
    logic [8:0] eg;
    if (chk_on) begin
      ix = idx_of(m);
      case (m.mode)
        M_SHOW:  er = 18'd1 << ix;
        M_ERR:   er = (((m.k / B) % 2) == 0) ? '1 : '0;
        M_SWEEP: er = 18'd1 << (m.k / S);
        default: er = '0;
      endcase
      eg = {5'(ix), m.mode == M_SWEEP, m.mode == M_ERR,
            m.mode == M_SHOW, m.mode == M_IDLE};
      tests++;
      if ({red, green, tens, units, valid} !==
          {er, eg, m.tens, m.units, m.valid}) begin
        fails++;
        $display("FAIL cycle t=%0t red=%h/%h green=%h/%h digits=%h%h/%h%h valid=%b/%b",
                 $time, red, er, green, eg, tens, units, m.tens, m.units,
                 valid, m.valid);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rst_lits(input string nm);
    lit({nm, "_red"}, 32'(red), 32'h0);
    lit({nm, "_green"}, 32'(green), 32'h001);
    lit({nm, "_tens"}, 32'(tens), 32'hF);
    lit({nm, "_units"}, 32'(units), 32'hF);
    lit({nm, "_valid"}, 32'(valid), 32'h0);
  endtask

  // lm: which buttons go low (bit0 load, bit1 clear)
  task automatic op(input logic [1:0] lm, input logic [7:0] s,
                    input int hold, input int gap);
    sw = s;
    btn = ~lm;
    repeat (hold) @(negedge clk);
    btn = 2'b11;
    repeat (gap) @(negedge clk);
  endtask

  task automatic async_reset(input string nm);
    #2 rst_n = 1'b0;
    #1 rst_lits(nm);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    sw = 8'h00;
    btn = 2'b11;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_lits("reset");

    // load 17: nothing visible after N+2, new state after N+3
    sw = 8'h17;
    btn = 2'b10;
    repeat (3) @(negedge clk);
    lit("ld17_before_valid", 32'(valid), 32'h0);
    @(negedge clk);
    lit("ld17_tens", 32'(tens), 32'h1);
    lit("ld17_units", 32'(units), 32'h7);
    lit("ld17_gidx", 32'(green[8:4]), 32'd17);
    lit("ld17_valid", 32'(valid), 32'h1);
`ifdef DECODER_SWEEP_EN
    lit("ld17_red", 32'(red), 32'h1);
`else
    lit("ld17_red", 32'(red), 32'h20000);
`endif
    repeat (10) @(negedge clk);
    btn = 2'b11;
    repeat (60) @(negedge clk);
    lit("ld17_final_red", 32'(red), 32'h20000);

    // 05 then invalid 18: blink 4 on / 4 off twice, back to SHOW 05
    op(2'b01, 8'h05, 4, 30);
    sw = 8'h18;
    btn = 2'b10;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 5) btn = 2'b11;
      if (j >= 4 && j < 20)
        lit("err_blink", 32'(red),
            ((((j - 4) / B) % 2) == 0) ? 32'h3FFFF : 32'h0);
    end
    lit("err_exit_red", 32'(red), 32'h20);
    lit("err_exit_tens", 32'(tens), 32'h0);
    lit("err_exit_units", 32'(units), 32'h5);
    lit("err_exit_valid", 32'(valid), 32'h1);

    // invalid entries from IDLE fall back to IDLE
    op(2'b10, 8'h00, 2, 10);
    op(2'b01, 8'h1A, 2, 25);
    rst_lits("idle_1A");
    op(2'b01, 8'h20, 2, 25);
    rst_lits("idle_20");

    // simultaneous load and clear: clear wins
    op(2'b01, 8'h12, 3, 70);
    op(2'b11, 8'h03, 3, 8);
    lit("both_red", 32'(red), 32'h0);
    lit("both_green", 32'(green), 32'h001);
    lit("both_valid", 32'(valid), 32'h0);

`ifdef DECODER_SWEEP_EN
    sw = 8'h04;
    btn = 2'b10;
    for (int j = 1; j <= 19; j++) begin
      @(negedge clk);
      if (j == 5) btn = 2'b11;
      if (j >= 4 && j < 19)
        lit("sweep_step", 32'(red), 32'h1 << ((j - 4) / S));
    end
    lit("sweep_done_red", 32'(red), 32'h10);
    lit("sweep_done_show", 32'(green[1]), 32'h1);
    op(2'b01, 8'h04, 2, 6);
    async_reset("sweep_rst");
`endif

    // reset in the middle of an error sequence
    op(2'b01, 8'h99, 2, 8);
    async_reset("err_rst");
    repeat (2) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] s;
      logic [1:0] lm;
      int r;
      int ix;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        ix = $urandom_range(0, 17);
        s = {4'(ix / 10), 4'(ix % 10)};
      end else begin
        s = 8'($urandom);
      end
      r = $urandom_range(0, 9);
      lm = (r < 7) ? 2'b01 : ((r < 9) ? 2'b10 : 2'b11);
      if ($urandom_range(0, 14) == 0) async_reset("rand_rst");
      else op(lm, s, $urandom_range(1, 8), $urandom_range(0, 30));
    end

    repeat (40) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
